// File: rtl/serv_gpu_dbus_arb.sv
// serv_gpu_dbus_arb
// -----------------------------------------------------------------------------
// Shared data-bus arbiter for the multi-core SERV GPU array. NUM_CORES
// Wishbone-style SERV data ports share one data memory. Grants are round-robin
// and only one access is in flight at a time. Two MMIO words are decoded
// locally and never reach memory:
//   DONE_ADDR    - write sets the caller's sticky done flag, read returns o_done
//   BARRIER_ADDR - holds the caller until every still-running core has arrived
//
// Optional feature macro: SERV_GPU_BARRIER_EN
//   defined   : BARRIER_ADDR is decoded and the barrier release logic exists
//   undefined : BARRIER_ADDR is an ordinary memory address, no barrier state
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   i_cyc/i_we        per-core request / write enable (request held until ack)
//   i_adr/i_dat       per-core address / write data, core k at [32k+:32]
//   i_sel             per-core byte selects, core k at [4k+:4]
//   o_ack             one-cycle per-core acknowledge
//   o_rdt             read data broadcast to all cores, valid with o_ack
//   o_mem_en          one-cycle memory strobe
//   o_mem_we/adr/dat/sel  memory command, valid while o_mem_en is high
//   i_mem_rdt         memory read data, valid MEM_LATENCY cycles after strobe
//   o_done/o_all_done sticky per-core done flags and their AND
//   o_gnt_idx         index of the currently granted core
// -----------------------------------------------------------------------------
module serv_gpu_dbus_arb #(
    parameter int unsigned NUM_CORES    = 4,
    parameter int unsigned MEM_LATENCY  = 1,
    parameter logic [31:0] DONE_ADDR    = 32'hFFFF_FFFC,
    parameter logic [31:0] BARRIER_ADDR = 32'hFFFF_FFF8,
    localparam int unsigned IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CORES-1:0]      i_cyc,
    input  logic [NUM_CORES-1:0]      i_we,
    input  logic [32*NUM_CORES-1:0]   i_adr,
    input  logic [32*NUM_CORES-1:0]   i_dat,
    input  logic [4*NUM_CORES-1:0]    i_sel,
    output logic [NUM_CORES-1:0]      o_ack,
    output logic [31:0]               o_rdt,
    output logic                      o_mem_en,
    output logic                      o_mem_we,
    output logic [31:0]               o_mem_adr,
    output logic [31:0]               o_mem_dat,
    output logic [3:0]                o_mem_sel,
    input  logic [31:0]               i_mem_rdt,
    output logic [NUM_CORES-1:0]      o_done,
    output logic                      o_all_done,
    output logic [IW-1:0]             o_gnt_idx
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_ACK    = 2'd3;

    localparam logic [2:0] LAT_LAST = 3'(MEM_LATENCY - 1);
    localparam logic [NUM_CORES-1:0] ALL_ONES = {NUM_CORES{1'b1}};
    localparam logic [NUM_CORES-1:0] NO_CORES = {NUM_CORES{1'b0}};

    // Registered state and outputs
    logic [1:0]           state_q,   state_d;
    logic [IW-1:0]        gnt_q,     gnt_d;
    logic [IW-1:0]        rr_ptr_q,  rr_ptr_d;
    logic [NUM_CORES-1:0] arrived_q, arrived_d;
    logic [NUM_CORES-1:0] mask_q;
    logic [NUM_CORES-1:0] done_q,    done_d;
    logic                 all_done_q;
    logic [NUM_CORES-1:0] ack_q,     ack_d;
    logic [31:0]          rdt_q,     rdt_d;
    logic [2:0]           lat_cnt_q, lat_cnt_d;
    logic                 mem_en_q,  mem_en_d;
    logic                 mem_we_q,  mem_we_d;
    logic [31:0]          mem_adr_q, mem_adr_d;
    logic [31:0]          mem_dat_q, mem_dat_d;
    logic [3:0]           mem_sel_q, mem_sel_d;

    // Combinational helpers
    logic [NUM_CORES-1:0] elig_s;
    logic                 found_s;
    logic [IW-1:0]        pick_s;
    logic [31:0]          idx_s;
    logic [31:0]          pick_adr_s;
    logic                 pick_mmio_s;
    logic [31:0]          g_adr_s;
    logic                 g_we_s;
    logic                 g_is_done_s;
    logic [IW-1:0]        rr_next_s;
`ifdef SERV_GPU_BARRIER_EN
    logic                 g_is_bar_s;
    logic [NUM_CORES-1:0] arrived_set_s;
    logic [NUM_CORES-1:0] arrived_next_s;
`endif

    function automatic logic is_done_addr(input logic [31:0] adr);
        return (adr == DONE_ADDR);
    endfunction

    function automatic logic is_mmio_addr(input logic [31:0] adr);
`ifdef SERV_GPU_BARRIER_EN
        return (adr == DONE_ADDR) || (adr == BARRIER_ADDR);
`else
        return (adr == DONE_ADDR);
`endif
    endfunction

    // A core that was just acked (this cycle or the last) still shows its old
    // cyc, so it is kept out of arbitration until it can have dropped it.
    assign elig_s = i_cyc & ~arrived_q & ~mask_q & ~ack_q;

    // Round-robin pick: first eligible core at or above rr_ptr, with wrap
    always_comb begin
        found_s = 1'b0;
        pick_s  = {IW{1'b0}};
        idx_s   = 32'd0;
        for (int i = 0; i < int'(NUM_CORES); i++) begin
            idx_s = 32'(rr_ptr_q) + 32'(i);
            if (idx_s >= 32'(NUM_CORES)) begin
                idx_s = idx_s - 32'(NUM_CORES);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && elig_s[idx_s[IW-1:0]]) begin
                found_s = 1'b1;
                pick_s  = idx_s[IW-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    assign pick_adr_s  = i_adr[32'd32 * 32'(pick_s) +: 32];
    assign pick_mmio_s = is_mmio_addr(pick_adr_s);
    assign g_adr_s     = i_adr[32'd32 * 32'(gnt_q) +: 32];
    assign g_we_s      = i_we[gnt_q];
    assign g_is_done_s = is_done_addr(g_adr_s);
`ifdef SERV_GPU_BARRIER_EN
    assign g_is_bar_s  = (g_adr_s == BARRIER_ADDR);
`endif
    assign rr_next_s   = (gnt_q == IW'(NUM_CORES - 1)) ? {IW{1'b0}} : gnt_q + IW'(1'b1);

    // Next-state logic: access FSM, then barrier release layered on top
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_ptr_d  = rr_ptr_q;
        done_d    = done_q;
        ack_d     = NO_CORES;
        rdt_d     = rdt_q;
        lat_cnt_d = lat_cnt_q;
        mem_en_d  = 1'b0;
        mem_we_d  = mem_we_q;
        mem_adr_d = mem_adr_q;
        mem_dat_d = mem_dat_q;
        mem_sel_d = mem_sel_q;
`ifdef SERV_GPU_BARRIER_EN
        arrived_set_s = NO_CORES;
`endif
        case (state_q)
            S_IDLE: begin
                if (found_s) begin
                    gnt_d   = pick_s;
                    state_d = S_ACCESS;
                    // The strobe is registered, so it is launched here to be
                    // high during the ACCESS cycle.
                    if (!pick_mmio_s) begin
                        mem_en_d  = 1'b1;
                        mem_we_d  = i_we[pick_s];
                        mem_adr_d = pick_adr_s;
                        mem_dat_d = i_dat[32'd32 * 32'(pick_s) +: 32];
                        mem_sel_d = i_sel[32'd4 * 32'(pick_s) +: 4];
                    end else begin
                        mem_en_d = 1'b0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (g_is_done_s) begin
                    if (g_we_s) begin
                        done_d[gnt_q] = 1'b1;
                    end else begin
                        rdt_d = 32'(done_q);
                    end
                    ack_d[gnt_q] = 1'b1;
                    state_d      = S_ACK;
`ifdef SERV_GPU_BARRIER_EN
                end else if (g_is_bar_s) begin
                    arrived_set_s[gnt_q] = 1'b1;
                    state_d              = S_IDLE;
`endif
                end else begin
                    lat_cnt_d = 3'd0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lat_cnt_q == LAT_LAST) begin
                    rdt_d        = i_mem_rdt;
                    ack_d[gnt_q] = 1'b1;
                    state_d      = S_ACK;
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end
            S_ACK: begin
                rr_ptr_d = rr_next_s;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef SERV_GPU_BARRIER_EN
        // Release is judged on next-state arrived/done so that the last
        // arrival (or a DONE write that completes the set) releases in the
        // following cycle. Arrivals only happen in ACCESS, so the zeroed read
        // data never collides with a memory read ack.
        arrived_next_s = arrived_q | arrived_set_s;
        if ((arrived_next_s != NO_CORES) && ((arrived_next_s | done_d) == ALL_ONES)) begin
            ack_d     = ack_d | arrived_next_s;
            rdt_d     = 32'd0;
            arrived_d = NO_CORES;
        end else begin
            arrived_d = arrived_next_s;
        end
`else
        arrived_d = NO_CORES;
`endif
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            gnt_q      <= {IW{1'b0}};
            rr_ptr_q   <= {IW{1'b0}};
            arrived_q  <= NO_CORES;
            mask_q     <= NO_CORES;
            done_q     <= NO_CORES;
            all_done_q <= 1'b0;
            ack_q      <= NO_CORES;
            rdt_q      <= 32'd0;
            lat_cnt_q  <= 3'd0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_adr_q  <= 32'd0;
            mem_dat_q  <= 32'd0;
            mem_sel_q  <= 4'd0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_ptr_q   <= rr_ptr_d;
            arrived_q  <= arrived_d;
            mask_q     <= ack_q;
            done_q     <= done_d;
            all_done_q <= &done_d;
            ack_q      <= ack_d;
            rdt_q      <= rdt_d;
            lat_cnt_q  <= lat_cnt_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            mem_adr_q  <= mem_adr_d;
            mem_dat_q  <= mem_dat_d;
            mem_sel_q  <= mem_sel_d;
        end
    end

    assign o_ack      = ack_q;
    assign o_rdt      = rdt_q;
    assign o_mem_en   = mem_en_q;
    assign o_mem_we   = mem_we_q;
    assign o_mem_adr  = mem_adr_q;
    assign o_mem_dat  = mem_dat_q;
    assign o_mem_sel  = mem_sel_q;
    assign o_done     = done_q;
    assign o_all_done = all_done_q;
    assign o_gnt_idx  = gnt_q;

endmodule

// File: tb/tb_serv_gpu_dbus_arb.sv
// Testbench for serv_gpu_dbus_arb (NUM_CORES=4, MEM_LATENCY=1).
// Table of single-core transactions with hand-computed results, followed by
// hand-written sequences: reset during WAIT, round-robin with all cores
// requesting, and (when SERV_GPU_BARRIER_EN is defined) a barrier release.
module tb_serv_gpu_dbus_arb;

    localparam logic [31:0] DONE_A = 32'hFFFF_FFFC;
    localparam logic [31:0] BAR_A  = 32'hFFFF_FFF8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   cyc = 4'h0;
    logic [3:0]   we  = 4'h0;
    logic [127:0] adr = 128'h0;
    logic [127:0] dat = 128'h0;
    logic [15:0]  sel = 16'h0;
    logic [31:0]  mem_rdt = 32'h0;

    logic [3:0]   o_ack;
    logic [31:0]  o_rdt;
    logic         o_mem_en;
    logic         o_mem_we;
    logic [31:0]  o_mem_adr;
    logic [31:0]  o_mem_dat;
    logic [3:0]   o_mem_sel;
    logic [3:0]   o_done;
    logic         o_all_done;
    logic [1:0]   o_gnt_idx;

    int checks = 0;
    int errors = 0;

    serv_gpu_dbus_arb #(.NUM_CORES(4), .MEM_LATENCY(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_cyc     (cyc),
        .i_we      (we),
        .i_adr     (adr),
        .i_dat     (dat),
        .i_sel     (sel),
        .o_ack     (o_ack),
        .o_rdt     (o_rdt),
        .o_mem_en  (o_mem_en),
        .o_mem_we  (o_mem_we),
        .o_mem_adr (o_mem_adr),
        .o_mem_dat (o_mem_dat),
        .o_mem_sel (o_mem_sel),
        .i_mem_rdt (mem_rdt),
        .o_done    (o_done),
        .o_all_done(o_all_done),
        .o_gnt_idx (o_gnt_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          core;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] mrdt;
        int          exp_mem_k;   // cycle of the strobe, 0 = no strobe
        int          exp_ack_k;
        logic        chk_rdt;
        logic [31:0] exp_rdt;
        logic [3:0]  exp_done;
        logic        exp_all;
    } vec_t;

    vec_t vq[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        int c;
        int mem_k, mem_n, ack_k;
        logic [3:0]  ack_v, done_v;
        logic [31:0] rdt_v, madr_v, mdat_v;
        logic        mwe_v, alld_v;
        logic [3:0]  msel_v;
        int          rr_order[5];
        int          rr_k[5];
        int          rr_g[5];
        int          n_ack;
        int          first_gnt;

        // Transaction table (MEM_LATENCY=1: strobe at cycle 1, memory ack at 3, MMIO ack at 2)
        vq.push_back('{2, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 32'hDEAD_BEEF, 1, 3, 1'b1, 32'hDEAD_BEEF, 4'h0, 1'b0});
        vq.push_back('{0, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'h3, 32'h0, 1, 3, 1'b0, 32'h0, 4'h0, 1'b0});
`ifndef SERV_GPU_BARRIER_EN
        vq.push_back('{1, 1'b1, BAR_A, 32'h55AA_55AA, 4'hF, 32'h0, 1, 3, 1'b0, 32'h0, 4'h0, 1'b0});
`endif
        vq.push_back('{3, 1'b1, DONE_A, 32'h0, 4'hF, 32'h0, 0, 2, 1'b0, 32'h0, 4'h8, 1'b0});
        vq.push_back('{1, 1'b0, DONE_A, 32'h0, 4'hF, 32'hBAD0_BAD0, 0, 2, 1'b1, 32'h0000_0008, 4'h8, 1'b0});
        vq.push_back('{0, 1'b1, DONE_A, 32'h0, 4'hF, 32'h0, 0, 2, 1'b0, 32'h0, 4'h9, 1'b0});
        vq.push_back('{1, 1'b1, DONE_A, 32'h0, 4'h1, 32'h0, 0, 2, 1'b0, 32'h0, 4'hB, 1'b0});
        vq.push_back('{2, 1'b1, DONE_A, 32'h0, 4'hF, 32'h0, 0, 2, 1'b0, 32'h0, 4'hF, 1'b1});
        vq.push_back('{2, 1'b0, DONE_A, 32'h0, 4'hF, 32'hBAD0_BAD0, 0, 2, 1'b1, 32'h0000_000F, 4'hF, 1'b1});

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("reset_ack",      32'(o_ack), 32'h0);
        chk("reset_rdt",      o_rdt, 32'h0);
        chk("reset_mem_en",   32'(o_mem_en), 32'h0);
        chk("reset_mem_adr",  o_mem_adr, 32'h0);
        chk("reset_done",     32'(o_done), 32'h0);
        chk("reset_all_done", 32'(o_all_done), 32'h0);
        chk("reset_gnt_idx",  32'(o_gnt_idx), 32'h0);
        rst = 1'b0;
        tick();

        // Table-driven single transactions
        for (int v = 0; v < vq.size(); v++) begin
            c = vq[v].core;
            we[c]          = vq[v].wr;
            adr[32*c +: 32] = vq[v].a;
            dat[32*c +: 32] = vq[v].d;
            sel[4*c +: 4]   = vq[v].s;
            mem_rdt         = vq[v].mrdt;
            cyc[c]          = 1'b1;
            mem_k = 0; mem_n = 0; ack_k = 0;
            ack_v = 4'h0; done_v = 4'h0; rdt_v = 32'h0; alld_v = 1'b0;
            madr_v = 32'h0; mdat_v = 32'h0; mwe_v = 1'b0; msel_v = 4'h0;
            for (int k = 1; k <= 12 && ack_k == 0; k++) begin
                tick();
                if (o_mem_en) begin
                    mem_n++;
                    if (mem_k == 0) begin
                        mem_k  = k;
                        madr_v = o_mem_adr;
                        mdat_v = o_mem_dat;
                        mwe_v  = o_mem_we;
                        msel_v = o_mem_sel;
                    end
                end
                if (o_ack != 4'h0) begin
                    ack_k  = k;
                    ack_v  = o_ack;
                    rdt_v  = o_rdt;
                    done_v = o_done;
                    alld_v = o_all_done;
                end
            end
            cyc[c] = 1'b0;
            we[c]  = 1'b0;
            chk($sformatf("v%0d_mem_count", v), 32'(mem_n), (vq[v].exp_mem_k != 0) ? 32'd1 : 32'd0);
            chk($sformatf("v%0d_mem_cycle", v), 32'(mem_k), 32'(vq[v].exp_mem_k));
            chk($sformatf("v%0d_ack_cycle", v), 32'(ack_k), 32'(vq[v].exp_ack_k));
            chk($sformatf("v%0d_ack_vec", v), 32'(ack_v), 32'(4'b0001 << c));
            chk($sformatf("v%0d_done", v), 32'(done_v), 32'(vq[v].exp_done));
            chk($sformatf("v%0d_all_done", v), 32'(alld_v), 32'(vq[v].exp_all));
            if (vq[v].chk_rdt) begin
                chk($sformatf("v%0d_rdt", v), rdt_v, vq[v].exp_rdt);
            end
            if (vq[v].exp_mem_k != 0) begin
                chk($sformatf("v%0d_mem_adr", v), madr_v, vq[v].a);
                chk($sformatf("v%0d_mem_we", v), 32'(mwe_v), 32'(vq[v].wr));
                chk($sformatf("v%0d_mem_sel", v), 32'(msel_v), 32'(vq[v].s));
                if (vq[v].wr) begin
                    chk($sformatf("v%0d_mem_dat", v), mdat_v, vq[v].d);
                end
            end
            tick();
            tick();
        end

        // Reset while a memory read by core 3 sits in WAIT
        we[3]          = 1'b0;
        adr[96 +: 32]  = 32'h0000_0300;
        mem_rdt        = 32'hCAFE_F00D;
        cyc[3]         = 1'b1;
        tick();
        chk("rstmid_strobe", 32'(o_mem_en), 32'h1);
        tick();
        rst = 1'b1;
        tick();
        chk("rstmid_ack",      32'(o_ack), 32'h0);
        chk("rstmid_done",     32'(o_done), 32'h0);
        chk("rstmid_all_done", 32'(o_all_done), 32'h0);
        chk("rstmid_mem_en",   32'(o_mem_en), 32'h0);
        rst    = 1'b0;
        cyc[3] = 1'b0;
        tick();
        tick();
        chk("rstmid_no_late_ack", 32'(o_ack), 32'h0);

        // Round-robin: all four cores read continuously; first grant is core 0
        for (int k = 0; k < 4; k++) begin
            adr[32*k +: 32] = 32'h0000_1000 + 32'(16 * k);
        end
        we       = 4'h0;
        rr_order = '{0, 1, 2, 3, 0};
        n_ack    = 0;
        first_gnt = -1;
        cyc      = 4'hF;
        for (int k = 1; k <= 40 && n_ack < 5; k++) begin
            tick();
            if (o_mem_en && first_gnt < 0) begin
                first_gnt = int'(o_gnt_idx);
                chk("rr_first_mem_adr", o_mem_adr, 32'h0000_1000);
            end
            if (o_ack != 4'h0) begin
                rr_k[n_ack] = k;
                rr_g[n_ack] = int'(o_gnt_idx);
                chk($sformatf("rr_ack%0d_vec", n_ack), 32'(o_ack), 32'(4'b0001 << rr_order[n_ack]));
                n_ack++;
            end
        end
        cyc = 4'h0;
        chk("rr_first_grant", 32'(first_gnt), 32'd0);
        chk("rr_ack_count", 32'(n_ack), 32'd5);
        if (n_ack == 5) begin
            chk("rr_first_ack_cycle", 32'(rr_k[0]), 32'd3);
            for (int i = 1; i < 5; i++) begin
                chk($sformatf("rr_ack%0d_spacing", i), 32'(rr_k[i] - rr_k[i-1]), 32'd4);
                chk($sformatf("rr_ack%0d_gnt", i), 32'(rr_g[i]), 32'(rr_order[i]));
            end
        end
        tick();
        tick();

`ifdef SERV_GPU_BARRIER_EN
        // Barrier: cores 0,1,3 arrive, core 2 finishes; one release of 4'b1011
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            adr[32*k +: 32] = (k == 2) ? DONE_A : BAR_A;
        end
        we    = 4'hF;
        cyc   = 4'hF;
        mem_n = 0;
        n_ack = 0;
        rdt_v = 32'hFFFF_FFFF;
        for (int k = 1; k <= 40 && cyc != 4'h0; k++) begin
            tick();
            if (o_mem_en) begin
                mem_n++;
            end
            if (o_ack == 4'b1011) begin
                n_ack++;
                rdt_v = o_rdt;
            end
            cyc = cyc & ~o_ack;
        end
        chk("bar_all_acked", 32'(cyc), 32'h0);
        chk("bar_mem_strobes", 32'(mem_n), 32'd0);
        chk("bar_release_count", 32'(n_ack), 32'd1);
        chk("bar_release_rdt", rdt_v, 32'h0);
        chk("bar_done", 32'(o_done), 32'h4);
        cyc = 4'h0;
        we  = 4'h0;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
